// File: rtl/stack_access_sequencer_if.sv
// Requester-side bundle of the shared-stack sequencer: both command ports,
// the grant pulses and the per-command status/response returned to the owner.
interface stack_access_sequencer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int LEN_W      = 4
);
  logic                  a_req;
  logic                  a_op;
  logic [LEN_W-1:0]      a_len;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  b_req;
  logic                  b_op;
  logic [LEN_W-1:0]      b_len;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  owner;
  logic                  beat;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  done;
  logic                  err;
  logic [LEN_W-1:0]      xfer_cnt;

  modport master (
    output a_req, a_op, a_len, a_wdata, b_req, b_op, b_len, b_wdata,
    input  a_gnt, b_gnt, owner, beat, rsp_valid, rsp_data, done, err, xfer_cnt
  );

  modport slave (
    input  a_req, a_op, a_len, a_wdata, b_req, b_op, b_len, b_wdata,
    output a_gnt, b_gnt, owner, beat, rsp_valid, rsp_data, done, err, xfer_cnt
  );
endinterface

// File: rtl/stack_access_sequencer.sv
// Round-robin sharing of one hardware stack between requesters A and B; each
// accepted command runs as a burst of single-cycle push/pop strobes.
module stack_access_sequencer_chk #(
  parameter int STACK_DEPTH = 16,
  parameter int LEN_W       = 4
) (
  input logic             clk,
  input logic             rst_edge,
  input logic             push_edge,
  input logic             citaj,
  input logic             citajVise,
  input logic             stack_full,
  input logic             stack_empty,
  input logic             done,
  input logic [LEN_W-1:0] xfer_cnt
);
  a_one_pop_kind: assert property (@(posedge clk) disable iff (rst_edge)
    !(citaj && citajVise));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst_edge)
    !(push_edge && stack_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst_edge)
    !((citaj || citajVise) && stack_empty));
  a_burst_fits: assert property (@(posedge clk) disable iff (rst_edge)
    done |-> (int'(xfer_cnt) <= STACK_DEPTH));
endmodule

module stack_access_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 16,
  parameter int LEN_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_edge,
  stack_access_sequencer_if.slave req_if,
  output logic                   push_edge,
  output logic                   citaj,
  output logic                   citajVise,
  output logic [DATA_WIDTH-1:0]  stack_wdata,
  input  logic                   stack_full,
  input  logic                   stack_empty,
  input  logic [DATA_WIDTH-1:0]  stack_rdata
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic                  prio_r;
  logic                  owner_r;
  logic                  op_r;
  logic [LEN_W-1:0]      len_r;
  logic [LEN_W-1:0]      cnt_r;
  logic                  a_gnt_r;
  logic                  b_gnt_r;
  logic                  done_r;
  logic                  err_r;
  logic [LEN_W-1:0]      xfer_cnt_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;

  logic                  pick_b_s;
  logic                  pick_op_s;
  logic [LEN_W-1:0]      pick_len_s;
  logic [LEN_W-1:0]      cnt_inc_s;
  logic                  active_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  blocked_s;

  // Arbitration winner: B only when A is idle or B holds the priority token
  always_comb begin
    pick_b_s   = 1'b0;
    pick_op_s  = 1'b0;
    pick_len_s = {LEN_W{1'b0}};
    if (req_if.b_req && (!req_if.a_req || prio_r)) begin
      pick_b_s   = 1'b1;
      pick_op_s  = req_if.b_op;
      pick_len_s = req_if.b_len;
    end else begin
      pick_op_s  = req_if.a_op;
      pick_len_s = req_if.a_len;
    end
  end

  // Strobe qualification; the grant cycle itself carries no beat
  always_comb begin
    cnt_inc_s = cnt_r + LEN_W'(1'b1);
    active_s  = (state_r == ST_XFER) && !(a_gnt_r || b_gnt_r);
    push_s    = active_s && !op_r && !stack_full;
    pop_s     = active_s && op_r && !stack_empty;
    blocked_s = active_s && (op_r ? stack_empty : stack_full);
  end

  // Push data follows the owner's live wdata only while a burst is running
  always_comb begin
    stack_wdata = {DATA_WIDTH{1'b0}};
    if (state_r == ST_XFER) begin
      if (owner_r) begin
        stack_wdata = req_if.b_wdata;
      end else begin
        stack_wdata = req_if.a_wdata;
      end
    end else begin
      stack_wdata = {DATA_WIDTH{1'b0}};
    end
  end

  assign push_edge = push_s;
  assign citaj     = pop_s && (len_r == LEN_W'(1'b1));
  assign citajVise = pop_s && (len_r != LEN_W'(1'b1));

  assign req_if.a_gnt     = a_gnt_r;
  assign req_if.b_gnt     = b_gnt_r;
  assign req_if.owner     = owner_r;
  assign req_if.beat      = push_s || pop_s;
  assign req_if.rsp_valid = rsp_valid_r;
  assign req_if.rsp_data  = rsp_data_r;
  assign req_if.done      = done_r;
  assign req_if.err       = err_r;
  assign req_if.xfer_cnt  = xfer_cnt_r;

  // Sequencer FSM with registered grant, status and response outputs
  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      state_r     <= ST_IDLE;
      prio_r      <= 1'b0;
      owner_r     <= 1'b0;
      op_r        <= 1'b0;
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      a_gnt_r     <= 1'b0;
      b_gnt_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      xfer_cnt_r  <= {LEN_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      a_gnt_r     <= 1'b0;
      b_gnt_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      xfer_cnt_r  <= {LEN_W{1'b0}};
      rsp_valid_r <= pop_s;
      if (pop_s) begin
        rsp_data_r <= stack_rdata;
      end
      case (state_r)
        ST_IDLE: begin
          if (req_if.a_req || req_if.b_req) begin
            a_gnt_r <= !pick_b_s;
            b_gnt_r <= pick_b_s;
            owner_r <= pick_b_s;
            prio_r  <= !pick_b_s;
            op_r    <= pick_op_s;
            len_r   <= pick_len_s;
            cnt_r   <= {LEN_W{1'b0}};
            if (pick_len_s == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (push_s || pop_s) begin
            cnt_r <= cnt_inc_s;
            if (cnt_inc_s == len_r) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              xfer_cnt_r <= cnt_inc_s;
            end
          end else if (blocked_s) begin
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            err_r      <= 1'b1;
            xfer_cnt_r <= cnt_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  stack_access_sequencer_chk #(
    .STACK_DEPTH (STACK_DEPTH),
    .LEN_W       (LEN_W)
  ) u_chk (
    .clk         (clk),
    .rst_edge    (rst_edge),
    .push_edge   (push_edge),
    .citaj       (citaj),
    .citajVise   (citajVise),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .done        (done_r),
    .xfer_cnt    (xfer_cnt_r)
  );
endmodule
